// File: rtl/logic_op_arbiter.sv
// Round-robin arbiter sharing one W-bit bitwise/logical op unit among N requesters,
// with a one-deep valid/ready output register. Optional zero flag: LOGIC_ARB_ZFLAG_EN.
module logic_op_arbiter #(
    parameter int N = 4,
    parameter int W = 8
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic [N-1:0]           i_req_valid,
    output logic [N-1:0]           o_req_ready,
    input  logic [4*N-1:0]         i_req_op,
    input  logic [W*N-1:0]         i_req_a,
    input  logic [W*N-1:0]         i_req_b,
    output logic                   o_out_valid,
    input  logic                   i_out_ready,
    output logic [W-1:0]           o_out_data,
    output logic [$clog2(N)-1:0]   o_out_id,
    output logic                   o_out_err
`ifdef LOGIC_ARB_ZFLAG_EN
    ,
    output logic                   o_out_zero
`endif
);

    localparam int IW = $clog2(N);

    localparam logic [0:0] ST_EMPTY = 1'b0;
    localparam logic [0:0] ST_FULL  = 1'b1;

    logic [0:0]    r_state;
    logic [IW-1:0] r_ptr;
    logic [W-1:0]  r_data;
    logic [IW-1:0] r_id;
    logic          r_err;

    logic [3:0]    w_op_arr [N];
    logic [W-1:0]  w_a_arr  [N];
    logic [W-1:0]  w_b_arr  [N];

    for (genvar gi = 0; gi < N; gi++) begin : g_unpack
        assign w_op_arr[gi] = i_req_op[4*gi +: 4];
        assign w_a_arr[gi]  = i_req_a[W*gi +: W];
        assign w_b_arr[gi]  = i_req_b[W*gi +: W];
    end

    logic          w_found;
    logic [IW-1:0] w_gnt;
    logic          w_can_accept;
    logic          w_grant;
    logic [IW-1:0] w_ptr_nxt;

    // Scan from the pointer upward, wrapping, and take the first valid requester.
    always_comb begin : p_search
        logic [IW:0] sum;
        logic [IW:0] idx;
        w_found = 1'b0;
        w_gnt   = '0;
        sum     = '0;
        idx     = '0;
        for (int k = 0; k < N; k++) begin
            sum = {1'b0, r_ptr} + (IW+1)'(k);
            idx = (sum >= (IW+1)'(N)) ? sum - (IW+1)'(N) : sum;
            if (!w_found && i_req_valid[idx[IW-1:0]]) begin
                w_found = 1'b1;
                w_gnt   = idx[IW-1:0];
            end
        end
    end

    assign w_can_accept = (r_state == ST_EMPTY) || i_out_ready;
    assign w_grant      = i_rst_n && w_can_accept && w_found;
    assign o_req_ready  = w_grant ? (N'(1) << w_gnt) : '0;
    assign w_ptr_nxt    = (w_gnt == IW'(N-1)) ? '0 : w_gnt + IW'(1);

    logic [3:0]   w_op;
    logic [W-1:0] w_a;
    logic [W-1:0] w_b;
    logic [W-1:0] w_res;
    logic         w_err;

    assign w_op = w_op_arr[w_gnt];
    assign w_a  = w_a_arr[w_gnt];
    assign w_b  = w_b_arr[w_gnt];

    always_comb begin
        w_res = '0;
        w_err = 1'b0;
        case (w_op)
            4'd0: w_res = w_a & w_b;
            4'd1: w_res = w_a | w_b;
            4'd2: w_res = ~(w_a & w_b);
            4'd3: w_res = ~(w_a | w_b);
            4'd4: w_res = w_a ^ w_b;
            4'd5: w_res = ~(w_a ^ w_b);
            4'd6: w_res = ~w_a;
            4'd7: w_res = w_a;
            4'd8: w_res = {{(W-1){1'b0}}, (|w_a) && (|w_b)};
            4'd9: w_res = {{(W-1){1'b0}}, (|w_a) || (|w_b)};
            default: w_err = 1'b1;
        endcase
    end

`ifdef LOGIC_ARB_ZFLAG_EN
    logic r_zero;
    always_ff @(posedge i_clk) begin
        if (!i_rst_n)     r_zero <= 1'b0;
        else if (w_grant) r_zero <= (w_res == '0);
    end
    assign o_out_zero = r_zero;
`endif

    // A grant while FULL only happens when the consumer takes the old result,
    // so reloading in place sustains one result per cycle.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state <= ST_EMPTY;
            r_ptr   <= '0;
            r_data  <= '0;
            r_id    <= '0;
            r_err   <= 1'b0;
        end else if (w_grant) begin
            r_state <= ST_FULL;
            r_ptr   <= w_ptr_nxt;
            r_data  <= w_res;
            r_id    <= w_gnt;
            r_err   <= w_err;
        end else if (r_state == ST_FULL && i_out_ready) begin
            r_state <= ST_EMPTY;
        end
    end

    assign o_out_valid = (r_state == ST_FULL);
    assign o_out_data  = r_data;
    assign o_out_id    = r_id;
    assign o_out_err   = r_err;

endmodule
